// File: rtl/eqed_sig_checker.sv
// eqed_sig_checker: E-QED signature checker.
// Folds the observed design-output lanes into a MISR over a programmable
// capture window. It then compares the final signature with the expected
// value latched at start, and reports a one-cycle done with a held pass/fail.
// Optional feature macro: EQED_CHK_FAILCNT_EN builds a saturating count of
// failed runs on fail_cnt. When the macro is undefined, fail_cnt is tied to 0.
// Handshake: start is a one-cycle request, accepted only in IDLE when abort is
// low. busy is high from the accepted start until the done pulse. abort cancels
// a run without producing done.
module eqed_sig_checker #(
    parameter int WIDTH = 6,
    parameter int LANES = 3,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] win_len,
    input  logic [WIDTH-1:0] exp_sig,
    input  logic [LANES-1:0] lanes,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [WIDTH-1:0] sig,
    output logic [7:0]       fail_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_COMPARE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] SEED = WIDTH'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] win_len_q;
    logic [WIDTH-1:0] exp_sig_q;
    logic [WIDTH-1:0] misr_nxt;
    logic             load_run;
    logic             step_en;
    logic             cmp_en;
    logic             abort_run;

    // cnt never exceeds win_len_q, so the increment cannot wrap
    assign cnt_inc = cnt_q + CNT_W'(1);

    // MISR feedback: bit 0 takes the two top bits plus lane 0. Every even
    // bit 2k (k < LANES) folds in lane k. All other bits are a plain shift.
    assign misr_nxt[0] = sig[WIDTH-1] ^ sig[WIDTH-2] ^ lanes[0];
    for (genvar j = 1; j < WIDTH; j++) begin : g_misr
        if ((j % 2 == 0) && (j / 2 < LANES)) begin : g_tap
            assign misr_nxt[j] = sig[j-1] ^ lanes[j/2];
        end else begin : g_shift
            assign misr_nxt[j] = sig[j-1];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; abort always wins over start and over progress
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort)
                    state_d = (win_len == '0) ? S_COMPARE : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (abort)                       state_d = S_IDLE;
                else if (cnt_inc == win_len_q)   state_d = S_COMPARE;
            end
            S_COMPARE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        load_run  = 1'b0;
        step_en   = 1'b0;
        cmp_en    = 1'b0;
        abort_run = 1'b0;
        case (state_q)
            S_IDLE:    load_run  = start && !abort;
            S_CAPTURE: begin
                step_en   = !abort;
                abort_run = abort;
            end
            S_COMPARE: begin
                cmp_en    = !abort;
                abort_run = abort;
            end
            default: ;
        endcase
    end

    // Datapath: seed/latch on start, step in CAPTURE, verdict in COMPARE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig       <= SEED;
            cnt_q     <= '0;
            win_len_q <= '0;
            exp_sig_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            done <= cmp_en;
            if (load_run) begin
                sig       <= SEED;
                cnt_q     <= '0;
                win_len_q <= win_len;
                exp_sig_q <= exp_sig;
                busy      <= 1'b1;
                pass      <= 1'b0;
                fail      <= 1'b0;
            end else if (step_en) begin
                sig   <= misr_nxt;
                cnt_q <= cnt_inc;
            end else if (cmp_en) begin
                pass <= (sig == exp_sig_q);
                fail <= (sig != exp_sig_q);
                busy <= 1'b0;
            end else if (abort_run) begin
                busy <= 1'b0;
                pass <= 1'b0;
                fail <= 1'b0;
            end
        end
    end

`ifdef EQED_CHK_FAILCNT_EN
    // Saturating failed-run counter, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fail_cnt <= 8'h00;
        else if (cmp_en && (sig != exp_sig_q) && (fail_cnt != 8'hFF))
            fail_cnt <= fail_cnt + 8'h01;
    end
`else
    assign fail_cnt = 8'h00;
`endif

endmodule

// File: doc/eqed_sig_checker.md
# eqed_sig_checker

Signature checker at the receiving end of the E-QED MISR path. Compresses the design-output lanes (x/y/z style single-bit outputs) into a MISR over a programmable capture window, then compares the final signature against an expected value and reports pass or fail. Sits beside the design under test in the E-QED wrapper and turns its output stream into a single verdict.

## Interface
Parameters:
- WIDTH, 6, MISR/signature width; must satisfy 2*LANES <= WIDTH
- LANES, 3, number of single-bit observed lanes
- CNT_W, 10, width of the window length and cycle counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous assert, active-low (0 = reset)
- start  input  1  one-cycle request to begin a capture run
- abort  input  1  cancels a run in progress
- win_len  input  CNT_W  capture window in cycles; latched on accepted start
- exp_sig  input  WIDTH  expected final signature; latched on accepted start
- lanes  input  LANES  observed design outputs (lane0=z, lane1=y, lane2=x)
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when the verdict is valid
- pass  output  1  final signature == latched exp_sig; held until next accepted start
- fail  output  1  final signature != latched exp_sig; held until next accepted start
- sig  output  WIDTH  live MISR contents
- fail_cnt  output  8  saturating failed-run count (see Configuration)

## Operation
- States: IDLE, CAPTURE, COMPARE. Reset enters IDLE.
- IDLE: start=1 accepted: sig <= seed 'b1 (bit0=1, rest 0), latch win_len and exp_sig, cnt <= 0, clear pass/fail, busy=1. Next state CAPTURE if win_len != 0, else COMPARE.
- CAPTURE: every cycle, MISR step and cnt+1; when cnt+1 == latched win_len, go to COMPARE.
- MISR step (bit 0 = LSB): next[0] = sig[WIDTH-1]^sig[WIDTH-2]^lanes[0]; for j>0, next[j] = sig[j-1] ^ (lanes[j/2] if j even and j/2 < LANES, else 0).
- COMPARE: register pass/fail from sig vs latched exp_sig, pulse done, clear busy, return to IDLE. sig is not stepped in COMPARE and holds until the next start.
- start while busy: ignored. abort=1 in CAPTURE or COMPARE: return to IDLE, busy=0, no done, pass=fail=0, sig holds. start and abort in the same cycle: abort wins; from IDLE nothing happens.
- cnt never wraps: win_len max is 2^CNT_W-1.
- Reset mid-run: all state cleared immediately and asynchronously; no done.

## Timing
- Reset values: busy=0, done=0, pass=0, fail=0, sig='b1, fail_cnt=0, state IDLE.
- start sampled at edge T: seed loaded at T; lanes sampled at edges T+1..T+win_len; done, pass and fail visible after edge T+win_len+1.
- win_len=0: done after edge T+1, comparing the seed.
- Back-to-back runs: start is accepted in the cycle after done (IDLE); minimum run period is win_len+2 cycles.

## Configuration
- EQED_CHK_FAILCNT_EN defined: fail_cnt increments on each done with fail=1 and saturates at 8'hFF; it is cleared only by reset.
- EQED_CHK_FAILCNT_EN undefined: fail_cnt is tied to 0 and no counter is built.

## Test plan
- Reset held low, then released: all outputs at reset values; sig=6'h01; busy=0.
- start, win_len=1, lanes=3'b000, exp_sig=6'h02: sig=6'h02; done two cycles after start; pass=1.
- start, win_len=1, lanes=3'b111, exp_sig=6'h17: pass=1. Same stimulus with exp_sig=6'h02: fail=1, and fail_cnt=1 when EQED_CHK_FAILCNT_EN is defined.
- start, win_len=0, exp_sig=6'h01: done one cycle after start with pass=1. start, win_len=2, lanes=0: sig=6'h04.
- start, win_len=5; abort in cycle 3: no done, busy=0. A second start in the same cycle as an abort is ignored. start during busy is ignored.
- rst pulled low mid-CAPTURE: outputs return to reset values asynchronously; a fresh run afterwards behaves as in the second scenario.
